imem_arbiter: RTL
=================

# imem_arbiter

Shares the single synchronous read port of the instruction memory between two requesters: the instruction-fetch (IF) stage and the load/store unit's read-only path (LS, for constant/literal loads from the text region). Sits between the IF/MEM pipeline stages and the memory macro. Arbitrates with LSU priority plus a starvation guard for fetch, issues at most one read per cycle, and routes the one-cycle-later read data back to the owner of the access, with flush support for speculative fetches.

## Interface
- STARVE_MAX, default 4: maximum consecutive LS grants issued while IF is requesting before IF is forcibly granted; legal range 1..15.
- ADDR_W, default 32: byte-address width.
- DATA_W, default 32: read data width.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous and active-low.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_flush_i  in  1  discard any fetch response due next cycle.
- if_gnt_o  out  1  fetch request accepted this cycle (combinational).
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DATA_W  fetch read data.
- ls_req_i  in  1  LS read request.
- ls_addr_i  in  ADDR_W  LS byte address.
- ls_gnt_o  out  1  LS request accepted this cycle (combinational).
- ls_rvalid_o  out  1  LS read data valid.
- ls_rdata_o  out  DATA_W  LS read data.
- mem_rden_o  out  1  memory read enable.
- mem_addr_o  out  ADDR_W  memory byte address.
- mem_rdata_i  in  DATA_W  memory read data, registered inside memory, valid the cycle after mem_rden_o.

## Operation
- Grant rule, per cycle:
  - only one requester active → grant it;
  - both active → grant LS, unless starve_cnt == STARVE_MAX, then grant IF.
- starve_cnt, 4 bits:
  - increments when LS is granted while if_req_i is high;
  - clears when IF is granted or if_req_i is low;
  - saturates at STARVE_MAX.
- mem_rden_o = if_gnt_o | ls_gnt_o.
- mem_addr_o:
  - ls_addr_i when LS is granted;
  - otherwise if_addr_i, passed through unmodified with no alignment.
- Owner register, owner_q ∈ {OWN_NONE, OWN_IF, OWN_LS}: loaded every cycle with the owner of this cycle's grant, or OWN_NONE if no grant.
- if_flush_i high in cycle N: owner_q == OWN_IF is treated as OWN_NONE for the response in cycle N. A new IF request granted in cycle N is unaffected.
- Response outputs:
  - if_rvalid_o = (owner_q == OWN_IF) & ~if_flush_i;
  - ls_rvalid_o = (owner_q == OWN_LS);
  - each rdata output = mem_rdata_i when its rvalid is high, else 0.
- Requesters must accept a response in the cycle it is valid. There is no response backpressure.
- Requesters hold req/addr until granted. Address changes before grant are legal; the granted address is the one present in the grant cycle.

## Timing
- Request → grant: 0 cycles (combinational).
- Grant in cycle N → rvalid and rdata in cycle N+1.
- Throughput: one read per cycle, back-to-back grants to either requester.
- Reset values: owner_q = OWN_NONE, starve_cnt = 0, both rvalid = 0, both rdata = 0.
- While rst_ni is low, if_gnt_o, ls_gnt_o and mem_rden_o are forced to 0.
- Reset asserted mid-access: the outstanding response is dropped, and no rvalid is produced after reset release.
- Simultaneous flush and IF grant: the old response is killed and the new request is granted; its rvalid appears in N+1 unless flushed again.
- STARVE_MAX reached while ls_req_i drops in the same cycle: IF is granted by the single-requester rule and the counter clears.

## Structure
- Package imem_arb_pkg holds:
  - owner_e enum (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_LS=2'd2);
  - the STARVE_CNT_W = 4 constant.
- Sub-module imem_arb_starve_cnt: saturating counter with inc/clr inputs, parameter MAX, and an at_max output.
- Top level holds the grant logic, owner_q and response routing. RTL target is about 150 lines.

## Test plan
- IF only, addresses 0x0, 0x4, 0x8 back-to-back → if_gnt_o each cycle. if_rvalid_o in cycles 1..3 with mem words at 0x0/0x4/0x8. ls_rvalid_o stays 0.
- IF and LS both request continuously, STARVE_MAX=4 → grant pattern LS,LS,LS,LS,IF repeating. starve_cnt reads 0,1,2,3,4,0.
- IF granted at 0x10 in cycle N, if_flush_i high in N+1 with a new IF grant at 0x40 → no if_rvalid_o in N+1. if_rvalid_o in N+2 with the word at 0x40.
- LS at 0x1002 (unaligned) → mem_addr_o = 0x1002 in the grant cycle. ls_rdata_o = {m[0x1005],m[0x1004],m[0x1003],m[0x1002]} one cycle later.
- rst_ni pulsed low between the grant and response cycles of an LS read → ls_rvalid_o stays 0. All outputs are 0 during reset. Normal grants resume the first cycle after release.
- No requests for 3 cycles → mem_rden_o = 0, both rvalid = 0, both rdata = 0, starve_cnt = 0.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory read-port arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/imem_arbiter_if.sv
// Request, response and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              mem_rden_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_addr_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
               mem_rden_o, mem_addr_o
    );

    // Requesters plus memory macro side.
    modport master (
        output if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_addr_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
               mem_rden_o, mem_addr_o
    );
endinterface

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive LS grants taken while fetch was waiting.
module imem_arb_starve_cnt
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction memory read port between fetch and the LS read path:
// LS priority with a fetch starvation guard, one read per cycle, routed response.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    imem_arbiter_if.slave  bus
);

    logic              if_gnt;
    logic              ls_gnt;
    logic              at_max;
    logic              starve_inc;
    logic              starve_clr;
    logic [ADDR_W-1:0] mem_addr;
    logic              if_rvalid;
    logic              ls_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] ls_rdata;
    owner_e            owner_q, owner_d;

    // Grants are gated by rst_ni so nothing reaches the memory while reset is held.
    always_comb begin
        ls_gnt     = rst_ni & bus.ls_req_i & ~(bus.if_req_i & at_max);
        if_gnt     = rst_ni & bus.if_req_i & ~ls_gnt;
        starve_inc = ls_gnt & bus.if_req_i;
        starve_clr = if_gnt | ~bus.if_req_i;

        owner_d = OWN_NONE;
        if (ls_gnt) begin
            owner_d = OWN_LS;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end

        mem_addr = '0;
        if (rst_ni) begin
            mem_addr = ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
        end
    end

    imem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .at_max_o (at_max)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // A flush only kills the fetch response arriving this cycle, never this cycle's grant.
    always_comb begin
        if_rvalid = (owner_q == OWN_IF) & ~bus.if_flush_i;
        ls_rvalid = (owner_q == OWN_LS);
        if_rdata  = if_rvalid ? bus.mem_rdata_i : '0;
        ls_rdata  = ls_rvalid ? bus.mem_rdata_i : '0;
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.mem_rden_o  = if_gnt | ls_gnt;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.ls_rvalid_o = ls_rvalid;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.ls_rdata_o  = ls_rdata;

endmodule
